// File: rtl/glyph_plotter_pkg.sv
// rtl/glyph_plotter_pkg.sv - shared glyph geometry, widths and FSM encoding
package glyph_plotter_pkg;

  localparam int GLYPH_W = 4;
  localparam int GLYPH_H = 5;
  localparam int CODE_W  = 4;
  localparam int POS_W   = 8;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COL_W   = 2;
  localparam int ROW_W   = 3;
  localparam int ADDR_W  = CODE_W + ROW_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Font rows are stored MSB-left, so column c lives at bit (W-1-c), i.e. ~c for 2-bit c.
  function automatic logic pixel_at(input logic [GLYPH_W-1:0] row_bits,
                                    input logic [COL_W-1:0] col);
    return row_bits[~col];
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// rtl/glyph_rom.sv - 16-entry hex-digit font, one 4-bit row per read, 1-cycle registered output
module glyph_rom
  import glyph_plotter_pkg::*;
(
  input  logic                 clock,
  input  logic [ADDR_W-1:0]    addr,
  output logic [GLYPH_W-1:0]   data
);

  logic [GLYPH_W*GLYPH_H-1:0] glyph;
  logic [GLYPH_W-1:0]         data_d;

  always_comb begin
    glyph = '0;
    case (addr[ADDR_W-1 -: CODE_W])
      4'h0: glyph = 20'h69996;
      4'h1: glyph = 20'h26227;
      4'h2: glyph = 20'hE168F;
      4'h3: glyph = 20'hE161E;
      4'h4: glyph = 20'h99F11;
      4'h5: glyph = 20'hF8E1E;
      4'h6: glyph = 20'h68E96;
      4'h7: glyph = 20'hF1244;
      4'h8: glyph = 20'h69696;
      4'h9: glyph = 20'h69716;
      4'hA: glyph = 20'h69F99;
      4'hB: glyph = 20'hE9E9E;
      4'hC: glyph = 20'h78887;
      4'hD: glyph = 20'hE999E;
      4'hE: glyph = 20'hF8E8F;
      4'hF: glyph = 20'hF8E88;
      default: glyph = '0;
    endcase
  end

  // Row 0 is the top row, held in the most significant nibble.
  always_comb begin
    data_d = '0;
    case (addr[ROW_W-1:0])
      3'd0: data_d = glyph[19:16];
      3'd1: data_d = glyph[15:12];
      3'd2: data_d = glyph[11:8];
      3'd3: data_d = glyph[7:4];
      3'd4: data_d = glyph[3:0];
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    data <= data_d;
  end

endmodule

// File: rtl/glyph_plotter.sv
// rtl/glyph_plotter.sv - scans one 4x5 glyph from the font ROM, one pixel per clock, for vga
module glyph_plotter
  import glyph_plotter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  input  logic [POS_W-1:0]  pos_in,
  output logic              ready,
  output logic              done,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              colour,
  output logic [POS_W-1:0]  pos,
  output logic              plot
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(GLYPH_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_H - 1);

  state_e              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [POS_W-1:0]    pos_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    x_q;
  logic [ROW_W-1:0]    y_q;
  logic                ready_q;
  logic                done_q;
  logic                plot_q;
  logic                lit_q;
  logic [GLYPH_W-1:0]  rom_data;
  logic                last_pixel;

  assign last_pixel = (col_q == LAST_COL) && (row_q == LAST_ROW);

  glyph_rom u_rom (
    .clock (clock),
    .addr  ({code_q, row_q}),
    .data  (rom_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      pos_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      lit_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      plot_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && ready_q) begin
            code_q  <= code;
            pos_q   <= pos_in;
            col_q   <= '0;
            row_q   <= '0;
            ready_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          // x/y/plot register on the same edge as the ROM data, keeping them aligned.
          x_q    <= col_q;
          y_q    <= row_q;
          plot_q <= 1'b1;
          lit_q  <= 1'b1;
          if (last_pixel) begin
            state_q <= FLUSH;
          end else if (col_q == LAST_COL) begin
            col_q <= '0;
            row_q <= row_q + 3'd1;
          end else begin
            col_q <= col_q + 2'd1;
          end
        end
        FLUSH: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // lit_q masks the un-reset ROM register until the first pixel after reset.
  assign colour = lit_q & pixel_at(rom_data, x_q);
  assign x      = {{(X_W-COL_W){1'b0}}, x_q};
  assign y      = {{(Y_W-ROW_W){1'b0}}, y_q};
  assign pos    = pos_q;
  assign ready  = ready_q;
  assign done   = done_q;
  assign plot   = plot_q;

endmodule
